// File: rtl/mnist_pkg.sv
// Shared constants for the MNIST result bridge: CPU control/status bit map,
// timestamp width, bridge state type and the status word packer.
package mnist_pkg;

    localparam int CTRL_ACK_BIT   = 0;
    localparam int CTRL_FLUSH_BIT = 1;

    localparam int STAT_VALID_BIT = 0;
    localparam int STAT_OVF_BIT   = 1;
    localparam int STAT_CNT_LSB   = 2;
    localparam int STAT_CNT_W     = 9;
    localparam int STAT_TS_LSB    = 16;

    localparam int TS_W = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } bridge_state_e;

    function automatic logic [31:0] pack_status(
        input logic                  valid,
        input logic                  ovf,
        input logic [STAT_CNT_W-1:0] cnt,
        input logic [TS_W-1:0]       ts
    );
        logic [31:0] s;
        s                               = 32'h0000_0000;
        s[STAT_VALID_BIT]               = valid;
        s[STAT_OVF_BIT]                 = ovf;
        s[STAT_CNT_LSB +: STAT_CNT_W]   = cnt;
        s[STAT_TS_LSB +: TS_W]          = ts;
        return s;
    endfunction

endpackage

// File: rtl/mnist_sync_fifo.sv
// Synchronous FIFO storage for the result bridge. Exposes the head entry and
// the entry behind it so the bridge can register the next presented word.
module mnist_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         head_data,
    output logic [WIDTH-1:0]         next_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            wr_ptr_r <= push ? wr_ptr_r + AW'(1) : wr_ptr_r;
            rd_ptr_r <= pop  ? rd_ptr_r + AW'(1) : rd_ptr_r;
            count_r  <= count_r + CW'(push) - CW'(pop);
        end
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign next_data = mem_r[rd_ptr_r + AW'(1)];
    assign count     = count_r;
    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});

endmodule

// File: rtl/mnist_result_bridge.sv
// Buffers accelerator results and presents them to the CPU through PIO with a
// toggle-ack handshake. Optional per-entry timestamps: MNIST_RESULT_TIMESTAMP_EN.
module mnist_result_bridge
    import mnist_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] result_in,
    input  logic              result_valid,
    input  logic [31:0]       cpu_ctrl,
    output logic [DATA_W-1:0] pio_result_data,
    output logic [31:0]       pio_result_status
);

    localparam int CW = $clog2(DEPTH) + 1;
`ifdef MNIST_RESULT_TIMESTAMP_EN
    localparam int EW = DATA_W + TS_W;
`else
    localparam int EW = DATA_W;
`endif

    bridge_state_e     state_r;
    bridge_state_e     state_next_s;
    logic              ack_prev_r;
    logic              ovf_r;
    logic              ovf_next_s;
    logic              ack_s;
    logic              flush_s;
    logic              push_s;
    logic              pop_s;
    logic [CW-1:0]     count_s;
    logic [CW-1:0]     count_next_s;
    logic              full_s;
    logic              empty_s;
    logic [EW-1:0]     wr_entry_s;
    logic [EW-1:0]     head_s;
    logic [EW-1:0]     head2_s;
    logic [EW-1:0]     show_entry_s;
    logic [TS_W-1:0]   show_ts_s;
    logic [DATA_W-1:0] data_r;
    logic [31:0]       status_r;

    assign ack_s   = cpu_ctrl[CTRL_ACK_BIT] ^ ack_prev_r;
    assign flush_s = cpu_ctrl[CTRL_FLUSH_BIT];

`ifdef MNIST_RESULT_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_r;

    // Free-running cycle counter stamped onto each accepted result.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            ts_cnt_r <= {TS_W{1'b0}};
        end else begin
            ts_cnt_r <= ts_cnt_r + TS_W'(1);
        end
    end

    assign wr_entry_s = {ts_cnt_r, result_in};
    assign show_ts_s  = show_entry_s[EW-1 -: TS_W];
`else
    assign wr_entry_s = result_in;
    assign show_ts_s  = {TS_W{1'b0}};
`endif

    mnist_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .push      (push_s),
        .pop       (pop_s),
        .flush     (flush_s),
        .wr_data   (wr_entry_s),
        .head_data (head_s),
        .next_data (head2_s),
        .count     (count_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    // State register, ack edge tracker and sticky overflow.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_r    <= ST_IDLE;
            ack_prev_r <= cpu_ctrl[CTRL_ACK_BIT];
            ovf_r      <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            ack_prev_r <= cpu_ctrl[CTRL_ACK_BIT];
            ovf_r      <= ovf_next_s;
        end
    end

    // Handshake decode, next state and the entry that will be presented next.
    always_comb begin
        pop_s        = 1'b0;
        push_s       = 1'b0;
        ovf_next_s   = ovf_r;
        count_next_s = count_s;
        state_next_s = state_r;
        show_entry_s = head_s;
        if (flush_s) begin
            ovf_next_s   = 1'b0;
            count_next_s = {CW{1'b0}};
            state_next_s = ST_IDLE;
        end else begin
            pop_s = (state_r == ST_SHOW) && ack_s;
            if (result_valid) begin
                if (!full_s || pop_s) begin
                    push_s = 1'b1;
                end else begin
                    ovf_next_s = 1'b1;
                end
            end else begin
                push_s = 1'b0;
            end
            count_next_s = count_s + CW'(push_s) - CW'(pop_s);
            case (state_r)
                ST_IDLE: state_next_s = push_s ? ST_SHOW : ST_IDLE;
                ST_SHOW: state_next_s = (count_next_s == {CW{1'b0}}) ? ST_IDLE : ST_SHOW;
                default: state_next_s = ST_IDLE;
            endcase
            // A word pushed into an empty (or just-drained) FIFO bypasses storage read.
            if (pop_s) begin
                if (count_s == CW'(1)) begin
                    show_entry_s = wr_entry_s;
                end else begin
                    show_entry_s = head2_s;
                end
            end else if (empty_s) begin
                show_entry_s = wr_entry_s;
            end else begin
                show_entry_s = head_s;
            end
        end
    end

    // Registered PIO outputs, loaded with the post-edge view of the FIFO.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            data_r   <= {DATA_W{1'b0}};
            status_r <= 32'h0000_0000;
        end else if (state_next_s == ST_SHOW) begin
            data_r   <= show_entry_s[DATA_W-1:0];
            status_r <= pack_status(1'b1, ovf_next_s, STAT_CNT_W'(count_next_s), show_ts_s);
        end else begin
            data_r   <= {DATA_W{1'b0}};
            status_r <= pack_status(1'b0, ovf_next_s, STAT_CNT_W'(count_next_s), {TS_W{1'b0}});
        end
    end

    assign pio_result_data   = data_r;
    assign pio_result_status = status_r;

endmodule

// File: tb/tb_mnist_result_bridge.sv
// Self-checking bench for mnist_result_bridge: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_mnist_result_bridge;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 32;

    logic              sys_clk;
    logic              sys_rst_n;
    logic [DATA_W-1:0] result_in;
    logic              result_valid;
    logic [31:0]       cpu_ctrl;
    logic [DATA_W-1:0] pio_result_data;
    logic [31:0]       pio_result_status;

    int checks;
    int failures;

    typedef struct {
        logic [31:0] data;
        logic [15:0] ts;
    } entry_t;

    entry_t      m_q[$];
    logic        m_ovf;
    logic        m_ack_prev;
    logic [15:0] m_ts;
    logic        ack_bit;

    mnist_result_bridge #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .sys_clk           (sys_clk),
        .sys_rst_n         (sys_rst_n),
        .result_in         (result_in),
        .result_valid      (result_valid),
        .cpu_ctrl          (cpu_ctrl),
        .pio_result_data   (pio_result_data),
        .pio_result_status (pio_result_status)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        int n;
        n = m_q.size();
        s = 32'h0000_0000;
        s[0] = (n > 0);
        s[1] = m_ovf;
        s[10:2] = 9'(n);
`ifdef MNIST_RESULT_TIMESTAMP_EN
        if (n > 0) s[31:16] = m_q[0].ts;
`endif
        return s;
    endfunction

    function automatic logic [31:0] model_data();
        return (m_q.size() > 0) ? m_q[0].data : 32'h0000_0000;
    endfunction

    // One clock of the reference behaviour, given the inputs about to be sampled.
    task automatic model_step(input logic v, input logic [31:0] d, input logic [31:0] c);
        logic ack;
        logic pop;
        entry_t e;
        ack = (c[0] != m_ack_prev);
        m_ack_prev = c[0];
        if (c[1]) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            pop = ack && (m_q.size() > 0);
            if (v && m_q.size() == DEPTH && !pop) m_ovf = 1'b1;
            if (pop) void'(m_q.pop_front());
            if (v && m_q.size() < DEPTH) begin
                e.data = d;
                e.ts = m_ts;
                m_q.push_back(e);
            end
        end
        m_ts = m_ts + 16'd1;
    endtask

    task automatic compare_model(input string tag);
        check_eq({tag, ".data"}, 64'(pio_result_data), 64'(model_data()));
        check_eq({tag, ".status"}, 64'(pio_result_status), 64'(model_status()));
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic ack_toggle, input logic flush);
        if (ack_toggle) ack_bit = ~ack_bit;
        result_valid = v;
        result_in = d;
        cpu_ctrl = {$urandom_range(0, 32'h3FFF_FFFF), flush, ack_bit};
        cpu_ctrl[1:0] = {flush, ack_bit};
        model_step(v, d, cpu_ctrl);
        @(posedge sys_clk);
        #1;
        compare_model("model");
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        result_valid = 1'b1;
        result_in = 32'hDEAD_BEEF;
        ack_bit = 1'($urandom_range(0, 1));
        cpu_ctrl = {30'd0, 1'b0, ack_bit};
        m_q.delete();
        m_ovf = 1'b0;
        m_ts = 16'd0;
        m_ack_prev = ack_bit;
        @(posedge sys_clk);
        #1;
        check_eq("reset.data", 64'(pio_result_data), 64'd0);
        check_eq("reset.status", 64'(pio_result_status), 64'd0);
        sys_rst_n = 1'b1;
        result_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        sys_rst_n = 1'b0;
        result_valid = 1'b0;
        result_in = 32'd0;
        cpu_ctrl = 32'd0;
        ack_bit = 1'b0;
        do_reset();

        // Single result then ack
        drive(1'b1, 32'h0000_00AB, 1'b0, 1'b0);
        check_eq("single.data", 64'(pio_result_data), 64'h0000_00AB);
        check_eq("single.valid", 64'(pio_result_status[0]), 64'd1);
        check_eq("single.count", 64'(pio_result_status[10:2]), 64'd1);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        check_eq("single_ack.valid", 64'(pio_result_status[0]), 64'd0);
        check_eq("single_ack.data", 64'(pio_result_data), 64'd0);

        // Ordering
        for (int i = 1; i <= 3; i++) drive(1'b1, 32'(i), 1'b0, 1'b0);
        check_eq("order.count3", 64'(pio_result_status[10:2]), 64'd3);
        for (int i = 1; i <= 3; i++) begin
            check_eq("order.data", 64'(pio_result_data), 64'(i));
            drive(1'b0, 32'd0, 1'b1, 1'b0);
            check_eq("order.count", 64'(pio_result_status[10:2]), 64'(3 - i));
        end

        // Overflow and flush
        for (int i = 0; i < 17; i++) drive(1'b1, 32'(100 + i), 1'b0, 1'b0);
        check_eq("ovf.count", 64'(pio_result_status[10:2]), 64'd16);
        check_eq("ovf.sticky", 64'(pio_result_status[1]), 64'd1);
        check_eq("ovf.head", 64'(pio_result_data), 64'd100);
        drive(1'b1, 32'h0000_0777, 1'b1, 1'b0);
        check_eq("full_pop.count", 64'(pio_result_status[10:2]), 64'd16);
        check_eq("full_pop.head", 64'(pio_result_data), 64'd101);
        drive(1'b1, 32'h0000_0999, 1'b1, 1'b1);
        check_eq("flush.count", 64'(pio_result_status[10:2]), 64'd0);
        check_eq("flush.ovf", 64'(pio_result_status[1]), 64'd0);
        check_eq("flush.data", 64'(pio_result_data), 64'd0);

        // Simultaneous push and pop at count 1
        drive(1'b1, 32'h11, 1'b0, 1'b0);
        drive(1'b1, 32'h22, 1'b1, 1'b0);
        check_eq("simul.data", 64'(pio_result_data), 64'h22);
        check_eq("simul.count", 64'(pio_result_status[10:2]), 64'd1);
        check_eq("simul.valid", 64'(pio_result_status[0]), 64'd1);
        drive(1'b0, 32'd0, 1'b1, 1'b0);

        // Spurious ack in IDLE
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        drive(1'b1, 32'h55, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        check_eq("spurious.data", 64'(pio_result_data), 64'h55);
        check_eq("spurious.count", 64'(pio_result_status[10:2]), 64'd1);

        // Reset mid-stream
        drive(1'b1, 32'h66, 1'b0, 1'b0);
        do_reset();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 1) == 1, $urandom,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 59) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mnist_result_bridge.md
MNIST_RESULT_BRIDGE -- requirements
Module: mnist_result_bridge

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning result FIFO entries (power of 2, 2..256).
REQ-002 SHALL have parameter DATA_W, default 32, meaning accelerator result width.
REQ-003 SHALL have port sys_clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port sys_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port result_in  input  DATA_W  accelerator result word.
REQ-006 SHALL have port result_valid  input  1  one-cycle strobe qualifying result_in.
REQ-007 SHALL have port cpu_ctrl  input  32  CPU output PIO; bit0 ack toggle, bit1 flush level, others ignored.
REQ-008 SHALL have port pio_result_data  output  DATA_W  presented result word, to CPU input PIO.
REQ-009 SHALL have port pio_result_status  output  32  bit0 data_valid, bit1 overflow sticky, bits[10:2] entry count, bits[15:11] zero, bits[31:16] timestamp or zero.

Function
REQ-010 SHALL buffer results in FIFO order; presented word is the oldest entry; count includes it.
REQ-011 SHALL have two states: IDLE (count 0, data_valid 0), SHOW (count >= 1, data_valid 1).
REQ-012 SHALL transition IDLE->SHOW on the edge after result_valid; data visible one cycle after strobe.
REQ-013 SHALL detect ack as cpu_ctrl[0] differing from its registered previous value (ack_prev updated every cycle).
REQ-014 SHALL, on ack in SHOW, pop the presented entry; next entry visible the following cycle; SHOW->IDLE when count reaches 0.
REQ-015 SHALL ignore ack in IDLE (ack_prev still updated, no pop, no error).
REQ-016 SHALL, on simultaneous push and pop, perform both; count unchanged; when count is 1 the new word is presented next cycle with no data_valid gap.
REQ-017 SHALL, on push with FIFO full and no pop, drop result_in and set overflow; push with full plus pop is accepted.
REQ-018 SHALL, while cpu_ctrl[1] high, empty the FIFO, clear overflow, force IDLE, ignore result_valid and ack; ack_prev still tracks.
REQ-019 SHALL hold pio_result_data stable while in SHOW with no pop; in IDLE it SHALL read zero.
REQ-020 SHALL wrap read/write pointers modulo DEPTH; count width is clog2(DEPTH)+1.
REQ-021 SHALL drive all outputs from registers (no combinational path from inputs to outputs).

Reset
REQ-022 SHALL, with sys_rst_n low at an edge, clear pointers, count, overflow, timestamp counter; ack_prev takes cpu_ctrl[0]; state IDLE.
REQ-023 SHALL reset all outputs to zero; reset mid-stream discards buffered results.

Configuration
REQ-024 SHALL honour macro MNIST_RESULT_TIMESTAMP_EN: defined -> free-running 16-bit cycle counter, wrapping, captured per pushed entry, presented in status[31:16]; undefined -> no counter/storage, status[31:16] constant zero.

Structure
REQ-025 SHALL take status bit positions, ctrl bit positions, and timestamp width from shared package mnist_pkg.
REQ-026 SHALL instantiate one sub-module mnist_sync_fifo (storage, pointers, full/empty); control, handshake, status in the bridge.

Verification
REQ-027 Single result: reset, result_valid with 0x0000_00AB -> next cycle data 0x0000_00AB, status[0]=1, count=1; toggle ack -> next cycle status[0]=0, data 0.
REQ-028 Ordering: push 1,2,3 back-to-back -> read 1,2,3 via three ack toggles; count 3,2,1,0.
REQ-029 Overflow: DEPTH=16, push 17 words no ack -> count 16, status[1]=1, 17th word never read; flush -> count 0, status[1]=0.
REQ-030 Simultaneous: count 1 holding 0x11, push 0x22 same cycle as ack -> next cycle data 0x22, count 1, data_valid never 0.
REQ-031 Spurious ack: ack toggle in IDLE, then push 0x55 -> 0x55 presented, not popped.
REQ-032 Timestamp (macro defined): push at counter 0x0010 -> status[31:16]=0x0010; undefined -> 0.
